// File: rtl/falling_fifo_pkg.sv
// -----------------------------------------------------------------------------
// falling_fifo_pkg
// Purpose : shared types for the falling-edge FIFO. It classifies each edge
//           by which transfers (push, pop) were accepted, so the occupancy
//           update reads as a small decode.
// Contents: fifo_op_e   - accepted-transfer classification for one edge
//           classify_op - builds a fifo_op_e from the accepted push/pop bits
// -----------------------------------------------------------------------------
package falling_fifo_pkg;

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e classify_op(input logic push_acc, input logic pop_acc);
      return fifo_op_e'({push_acc, pop_acc});
   endfunction

endpackage : falling_fifo_pkg

// File: rtl/falling_fifo_reg.sv
// -----------------------------------------------------------------------------
// falling_register_param
// Purpose : one FIFO storage word. It is a WIDTH-bit register that loads on the
//           falling clock edge when enabled and clears asynchronously while
//           reset is low.
// Ports   : clock      - clock, active on the falling edge
//           ctrl_reset - asynchronous active-low clear
//           en_i       - load enable
//           d_i        - word to load
//           q_o        - stored word
// -----------------------------------------------------------------------------
module falling_register_param
   import falling_fifo_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clock,
   input  logic             ctrl_reset,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(negedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule : falling_register_param

// File: rtl/falling_fifo.sv
// -----------------------------------------------------------------------------
// falling_fifo
// Purpose : a first-word-fall-through FIFO. All state changes happen on the
//           falling clock edge. It has sticky overflow and underflow flags and
//           a synchronous flush.
// Ports   : clock            - sole clock (falling edge active)
//           ctrl_reset       - asynchronous active-low reset
//           ctrl_writeEnable - push request
//           ctrl_readEnable  - pop request
//           ctrl_flush       - synchronous clear of pointers, count and flags
//           data_in          - word to push
//           data_out         - head word, zero when empty
//           count            - occupancy 0..DEPTH
//           empty / full     - occupancy status
//           overflow         - sticky, set by a rejected push
//           underflow        - sticky, set by a rejected pop
// DEPTH must be a power of two (at least 2), so that the pointers wrap
// naturally modulo DEPTH.
// -----------------------------------------------------------------------------
module falling_fifo
   import falling_fifo_pkg::*;
#(
   parameter  int WIDTH = 5,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             ctrl_reset,
   input  logic             ctrl_writeEnable,
   input  logic             ctrl_readEnable,
   input  logic             ctrl_flush,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             pop_acc, push_acc;
   fifo_op_e         op;
   logic [DEPTH-1:0] entry_en;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);

   // A push into a full FIFO is still accepted when a pop frees the head slot
   // on the same edge. Flush masks both transfers, so it also gates the
   // storage write enables.
   assign pop_acc  = ctrl_readEnable && !empty && !ctrl_flush;
   assign push_acc = ctrl_writeEnable && (!full || (ctrl_readEnable && !empty)) && !ctrl_flush;
   assign op       = classify_op(push_acc, pop_acc);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (ctrl_flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         unique case (op)
            OP_PUSH: count_d = count_q + CNT_ONE;
            OP_POP:  count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (ctrl_writeEnable && !push_acc) overflow_d  = 1'b1;
         if (ctrl_readEnable  && !pop_acc)  underflow_d = 1'b1;
      end
   end

   always_ff @(negedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign entry_en[i] = push_acc && (wr_ptr_q == AW'(i));

      falling_register_param #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clock      (clock),
         .ctrl_reset (ctrl_reset),
         .en_i       (entry_en[i]),
         .d_i        (data_in),
         .q_o        (mem[i])
      );
   end

   // The head is visible as soon as it is written. It is forced to zero while
   // empty so that stale words from popped or flushed entries never leak out.
   assign data_out  = empty ? '0 : mem[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule : falling_fifo

// File: tb/tb_falling_fifo.sv
module tb_falling_fifo;

   logic       clock;
   logic       ctrl_reset;
   logic       ctrl_writeEnable;
   logic       ctrl_readEnable;
   logic       ctrl_flush;
   logic [4:0] data_in;
   logic [4:0] data_out;
   logic [3:0] count;
   logic       empty;
   logic       full;
   logic       overflow;
   logic       underflow;

   int vectors;
   int miscompares;

   logic [4:0] sb[$];
   logic       ovf_m;
   logic       unf_m;

   falling_fifo #(
      .WIDTH (5),
      .DEPTH (8)
   ) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_readEnable  (ctrl_readEnable),
      .ctrl_flush       (ctrl_flush),
      .data_in          (data_in),
      .data_out         (data_out),
      .count            (count),
      .empty            (empty),
      .full             (full),
      .overflow         (overflow),
      .underflow        (underflow)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [4:0] head;
      head = (sb.size() > 0) ? sb[0] : 5'h00;
      check({tag, ".count"},     32'(count),     32'(sb.size()));
      check({tag, ".empty"},     32'(empty),     32'(sb.size() == 0));
      check({tag, ".full"},      32'(full),      32'(sb.size() == 8));
      check({tag, ".overflow"},  32'(overflow),  32'(ovf_m));
      check({tag, ".underflow"}, 32'(underflow), 32'(unf_m));
      check({tag, ".data_out"},  32'(data_out),  32'(head));
   endtask

   // One falling-edge transaction: inputs change on the rising edge, the popped
   // word is compared before the active edge, state is compared after it.
   task automatic step(input string tag, input logic we, input logic re,
                       input logic fl, input logic [4:0] din);
      logic pop_ok;
      logic push_ok;
      logic [4:0] exp_word;
      @(posedge clock);
      ctrl_writeEnable = we;
      ctrl_readEnable  = re;
      ctrl_flush       = fl;
      data_in          = din;
      #1;
      if (fl) begin
         sb.delete();
         ovf_m = 1'b0;
         unf_m = 1'b0;
      end else begin
         pop_ok  = re && (sb.size() > 0);
         push_ok = we && ((sb.size() < 8) || pop_ok);
         if (re && !pop_ok) unf_m = 1'b1;
         if (we && !push_ok) ovf_m = 1'b1;
         if (pop_ok) begin
            exp_word = sb.pop_front();
            check({tag, ".pop_word"}, 32'(data_out), 32'(exp_word));
         end
         if (push_ok) sb.push_back(din);
      end
      @(negedge clock);
      #1;
      ctrl_writeEnable = 1'b0;
      ctrl_readEnable  = 1'b0;
      ctrl_flush       = 1'b0;
      check_state(tag);
   endtask

   // Reset pulse placed between edges; outputs must clear with no clock edge.
   task automatic async_reset(input string tag);
      #2;
      ctrl_reset = 1'b0;
      sb.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      #1;
      check_state(tag);
      #1;
      ctrl_reset = 1'b1;
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      ovf_m            = 1'b0;
      unf_m            = 1'b0;
      ctrl_reset       = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_readEnable  = 1'b0;
      ctrl_flush       = 1'b0;
      data_in          = '0;

      #2;
      check_state("reset");
      #1;
      ctrl_reset = 1'b1;

      // fill to full
      for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 1'b0, 5'(i));

      // rejected push, then drain in order
      step("ovf_push", 1'b1, 1'b0, 1'b0, 5'h1F);
      for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 1'b0, 5'h00);

      // pop on empty, then flush clears the flag
      step("unf_pop", 1'b0, 1'b1, 1'b0, 5'h00);
      step("flush1", 1'b0, 1'b0, 1'b1, 5'h00);

      // full with simultaneous push and pop across several wraps
      for (int i = 1; i <= 8; i++) step("fill2", 1'b1, 1'b0, 1'b0, 5'(i));
      for (int i = 0; i < 20; i++) step("stream", 1'b1, 1'b1, 1'b0, 5'(16 + i));
      for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1, 1'b0, 5'h00);

      // push and pop together on empty: only the push lands
      step("both_empty", 1'b1, 1'b1, 1'b0, 5'h15);
      step("flush2", 1'b0, 1'b0, 1'b1, 5'h00);

      // flush wins over push and pop on the same edge
      step("unf_pre", 1'b0, 1'b1, 1'b0, 5'h00);
      for (int i = 0; i < 3; i++) step("three", 1'b1, 1'b0, 1'b0, 5'(5'h1A + i));
      step("flush_ovr", 1'b1, 1'b1, 1'b1, 5'h07);

      // asynchronous reset with contents present
      for (int i = 0; i < 4; i++) step("four", 1'b1, 1'b0, 1'b0, 5'(5'h11 + i));
      async_reset("mid_reset");
      step("post_reset", 1'b1, 1'b0, 1'b0, 5'h0A);

      // random mix
      for (int i = 0; i < 80; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_falling_fifo
